// File: rtl/alu_share_arbiter_if.sv
// Request/response bus between the requesters and the shared-ALU arbiter.
// The master side offers operations and consumes responses.
// The slave side is the arbiter.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 4,
    parameter int OPW     = 4
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*OPW-1:0] req_op;
    logic [NUM_REQ*DW-1:0]  req_a;
    logic [NUM_REQ*DW-1:0]  req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic [DW-1:0]          rsp_result;
    logic                   rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU among NUM_REQ requesters.
// The winning request is latched into registers that drive the ALU.
// The ALU result is captured one cycle later and returned on the response channel.
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 4,
    parameter int OPW     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_share_arbiter_if.slave     bus,
    output logic [OPW-1:0]         alu_op,
    output logic [DW-1:0]          alu_a,
    output logic [DW-1:0]          alu_b,
    input  logic [DW-1:0]          alu_result
);
    localparam int ID_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Opcodes above 5 have no ALU meaning and are reported as errors.
    function automatic logic op_illegal(input logic [OPW-1:0] op);
        return (op > OPW'(5));
    endfunction

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               err_q, err_d;
    logic [OPW-1:0]     alu_op_q, alu_op_d;
    logic [DW-1:0]      alu_a_q, alu_a_d;
    logic [DW-1:0]      alu_b_q, alu_b_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [DW-1:0]      rsp_result_q, rsp_result_d;
    logic               rsp_err_q, rsp_err_d;

    logic               grant_found_s;
    logic [ID_W-1:0]    grant_id_s;
    logic [2:0]         cand_sum_s;
    logic [OPW-1:0]     sel_op_s;
    logic [DW-1:0]      sel_a_s;
    logic [DW-1:0]      sel_b_s;
    logic [NUM_REQ-1:0] req_ready_s;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        cand_sum_s    = 3'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum_s = {1'b0, rr_q} + 3'(k);
            if (cand_sum_s >= 3'(NUM_REQ)) begin
                cand_sum_s = cand_sum_s - 3'(NUM_REQ);
            end else begin
                cand_sum_s = cand_sum_s;
            end
            if (!grant_found_s && bus.req_valid[cand_sum_s[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand_sum_s[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Fields of the currently granted requester.
    always_comb begin
        sel_op_s = bus.req_op[int'(grant_id_s)*OPW +: OPW];
        sel_a_s  = bus.req_a[int'(grant_id_s)*DW +: DW];
        sel_b_s  = bus.req_b[int'(grant_id_s)*DW +: DW];
    end

    // Accept strobe: one-hot to the winner, only while idle and out of reset.
    always_comb begin
        req_ready_s = {NUM_REQ{1'b0}};
        if (state_q == ST_IDLE && !rst && grant_found_s) begin
            req_ready_s[grant_id_s] = 1'b1;
        end else begin
            req_ready_s = {NUM_REQ{1'b0}};
        end
    end

    // FSM next state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        id_d         = id_q;
        err_d        = err_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    // An illegal opcode is replaced by a no-op so the ALU never sees it.
                    alu_op_d = op_illegal(sel_op_s) ? {OPW{1'b0}} : sel_op_s;
                    err_d    = op_illegal(sel_op_s);
                    alu_a_d  = sel_a_s;
                    alu_b_d  = sel_b_s;
                    id_d     = grant_id_s;
                    rr_d     = grant_id_s;
                    state_d  = ST_EXEC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_result_d = err_q ? {DW{1'b0}} : alu_result;
                rsp_id_d     = id_q;
                rsp_err_d    = err_q;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_q         <= ID_W'(NUM_REQ - 1);
            id_q         <= {ID_W{1'b0}};
            err_q        <= 1'b0;
            alu_op_q     <= {OPW{1'b0}};
            alu_a_q      <= {DW{1'b0}};
            alu_b_q      <= {DW{1'b0}};
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= {ID_W{1'b0}};
            rsp_result_q <= {DW{1'b0}};
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            id_q         <= id_d;
            err_q        <= err_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_op         = alu_op_q;
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign bus.req_ready  = req_ready_s;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 4-bit ALU attached.
module tb_alu_share_arbiter;
    logic       clk;
    logic       rst;
    logic [3:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_result;
    int         checks;
    int         failures;

    alu_share_arbiter_if #(.NUM_REQ(4), .DW(4), .OPW(4)) bus ();

    alu_share_arbiter #(.NUM_REQ(4), .DW(4), .OPW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    // External ALU model.
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = 4'h0;
            4'd1:    alu_result = ~alu_a;
            4'd2:    alu_result = ~alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a & alu_b;
            4'd5:    alu_result = alu_a ^ alu_b;
            default: alu_result = 4'hX;
        endcase
    end

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        bus.req_op[i*4 +: 4] = op;
        bus.req_a[i*4 +: 4]  = a;
        bus.req_b[i*4 +: 4]  = b;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [1:0] id,
                             input logic [3:0] res, input logic err);
        check_eq({tag, "_valid"},  32'(bus.rsp_valid),  32'(v));
        check_eq({tag, "_id"},     32'(bus.rsp_id),     32'(id));
        check_eq({tag, "_result"}, 32'(bus.rsp_result), 32'(res));
        check_eq({tag, "_err"},    32'(bus.rsp_err),    32'(err));
    endtask

    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] rr_res [5] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hF};

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_op    = 16'h0;
        bus.req_a     = 16'h0;
        bus.req_b     = 16'h0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state: everything zero, no accept even with requests pending.
        check_eq("rst_alu_op", 32'(alu_op), 32'h0);
        check_eq("rst_alu_a", 32'(alu_a), 32'h0);
        check_eq("rst_alu_b", 32'(alu_b), 32'h0);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check_rsp("rst", 1'b0, 2'd0, 4'h0, 1'b0);
        bus.req_valid = 4'h0;
        rst = 1'b0;

        // 1: requester 0 OR A|5 = F, two-cycle latency.
        set_req(0, 4'd3, 4'hA, 4'h5);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        #1;
        check_eq("t1_ready", 32'(bus.req_ready), 32'h1);
        next_cyc();
        bus.req_valid = 4'h0;
        #1;
        check_eq("t1_alu_op", 32'(alu_op), 32'h3);
        check_eq("t1_alu_a", 32'(alu_a), 32'hA);
        check_eq("t1_alu_b", 32'(alu_b), 32'h5);
        check_eq("t1_exec_ready", 32'(bus.req_ready), 32'h0);
        check_eq("t1_exec_valid", 32'(bus.rsp_valid), 32'h0);
        next_cyc();
        check_rsp("t1_rsp", 1'b1, 2'd0, 4'hF, 1'b0);
        next_cyc();
        check_eq("t1_done_valid", 32'(bus.rsp_valid), 32'h0);

        // 2: all requesters continuously valid after a fresh reset.
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 4'd5, 4'(i), 4'hF);
        bus.req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            #1;
            check_eq($sformatf("t2_grant%0d", n), 32'(bus.req_ready), 32'(1 << order[n]));
            next_cyc();
            check_eq($sformatf("t2_exec_ready%0d", n), 32'(bus.req_ready), 32'h0);
            next_cyc();
            check_rsp($sformatf("t2_rsp%0d", n), 1'b1, 2'(order[n]), rr_res[n], 1'b0);
            check_eq($sformatf("t2_resp_ready%0d", n), 32'(bus.req_ready), 32'h0);
            next_cyc();
        end
        bus.req_valid = 4'h0;

        // 3: requester 2 XOR C^A = 6 with a stalled consumer; requester 1 waits.
        set_req(2, 4'd5, 4'hC, 4'hA);
        set_req(1, 4'hF, 4'h3, 4'h3);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b0;
        #1;
        check_eq("t3_grant", 32'(bus.req_ready), 32'h4);
        next_cyc();
        bus.req_valid = 4'b0010;
        #1;
        check_eq("t3_exec_ready", 32'(bus.req_ready), 32'h0);
        next_cyc();
        for (int k = 0; k < 5; k++) begin
            check_rsp($sformatf("t3_hold%0d", k), 1'b1, 2'd2, 4'h6, 1'b0);
            check_eq($sformatf("t3_hold_ready%0d", k), 32'(bus.req_ready), 32'h0);
            next_cyc();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check_eq("t3_ack_valid", 32'(bus.rsp_valid), 32'h1);
        check_eq("t3_ack_ready", 32'(bus.req_ready), 32'h0);
        next_cyc();
        check_eq("t3_req1_grant", 32'(bus.req_ready), 32'h2);
        check_eq("t3_idle_valid", 32'(bus.rsp_valid), 32'h0);

        // 4: requester 1 illegal opcode F.
        next_cyc();
        bus.req_valid = 4'h0;
        check_eq("t4_alu_op", 32'(alu_op), 32'h0);
        check_eq("t4_alu_a", 32'(alu_a), 32'h3);
        next_cyc();
        check_rsp("t4_rsp", 1'b1, 2'd1, 4'h0, 1'b1);
        next_cyc();
        check_eq("t4_done_valid", 32'(bus.rsp_valid), 32'h0);

        // 5: reset during execution of requester 3 NOT A.
        set_req(3, 4'd1, 4'h0, 4'h0);
        bus.req_valid = 4'b1000;
        #1;
        check_eq("t5_grant", 32'(bus.req_ready), 32'h8);
        next_cyc();
        check_eq("t5_alu_op", 32'(alu_op), 32'h1);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_alu_op", 32'(alu_op), 32'h0);
        check_eq("t5_rst_ready", 32'(bus.req_ready), 32'h0);
        check_rsp("t5_rst", 1'b0, 2'd0, 4'h0, 1'b0);
        bus.req_valid = 4'h0;
        next_cyc();
        rst = 1'b0;
        next_cyc();
        check_eq("t5_no_rsp_a", 32'(bus.rsp_valid), 32'h0);
        next_cyc();
        check_eq("t5_no_rsp_b", 32'(bus.rsp_valid), 32'h0);

        // 6: requester 0 wins over 3 after reset; NOT B of 9 = 6, then no-op = 0.
        set_req(0, 4'd2, 4'h0, 4'h9);
        bus.req_valid = 4'b1001;
        #1;
        check_eq("t6_grant", 32'(bus.req_ready), 32'h1);
        next_cyc();
        bus.req_valid = 4'h0;
        next_cyc();
        check_rsp("t6_notb", 1'b1, 2'd0, 4'h6, 1'b0);
        next_cyc();
        set_req(0, 4'd0, 4'h5, 4'h7);
        bus.req_valid = 4'b0001;
        #1;
        check_eq("t6_grant_nop", 32'(bus.req_ready), 32'h1);
        next_cyc();
        bus.req_valid = 4'h0;
        next_cyc();
        check_rsp("t6_nop", 1'b1, 2'd0, 4'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
